spi_reg_slave: RTL and testbench
================================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 The block SHALL have parameter REG_COUNT, default 16, giving the number of 8-bit registers; the address width is 4 bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on SPI_SCLK, CS and MOSI (minimum 2).
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these SPI ports: SPI_SCLK  in  1  SPI clock; CS  in  1  chip select, active low; MOSI  in  1  initiator data; MISO  out  1  responder data, 'z' when deselected.
REQ-005 The block SHALL have these mode inputs: CPOL  in  1  clock polarity; CPHA  in  1  clock phase (mode stable while CS high).
REQ-006 The block SHALL have this local port: busy  out  1  transaction in progress; wr_valid  out  1  one-cycle pulse per SPI write; wr_addr  out  4  written address; wr_data  out  8  written data; loc_addr  in  4  local read address; loc_rdata  out  8  combinational register read.

Function
REQ-007 The block SHALL oversample: SPI_SCLK/CS/MOSI pass through SYNC_STAGES flops; edges are detected on the synchronized SCLK; supported SCLK is at most clk/8.
REQ-008 The sample edge SHALL be the leading edge (idle-to-active per CPOL) when CPHA=0 and the trailing edge when CPHA=1; the shift edge SHALL be the other edge.
REQ-009 The FSM SHALL have states IDLE, CMD and DATA: IDLE->CMD on synchronized CS low; CMD->DATA after 8 sampled bits; DATA->DATA per byte; any state->IDLE on synchronized CS high (priority over edges).
REQ-010 Bits SHALL be MSB first; the 3-bit bit counter SHALL reset to 0 on entry to CMD and on every byte completion.
REQ-011 The command byte SHALL be: bit7 = 1 read, 0 write; bits3:0 = start address; bits6:4 are ignored.
REQ-012 In write mode, each completed data byte SHALL update reg[addr] and pulse wr_valid for exactly one clk with wr_addr/wr_data, two clk cycles after the 8th sample edge is synchronized.
REQ-013 In read mode, reg[addr] SHALL load into the 8-bit tx shifter at byte completion, and MISO SHALL equal tx_shift[7].
REQ-014 The tx shifter SHALL shift left (fill 0) on shift edges; with CPHA=1 the first shift edge of each byte SHALL NOT shift; a load SHALL take priority over a shift in the same cycle.
REQ-015 During CMD, and during DATA in write mode, MISO SHALL drive 0.
REQ-016 After each data byte the address SHALL increment modulo 16 (wrap 15->0).
REQ-017 A partial byte at CS rise SHALL be discarded: no write and no wr_valid.
REQ-018 busy SHALL be 1 in CMD and DATA and 0 in IDLE.

Reset
REQ-019 On rst the block SHALL go to IDLE and clear all registers and shifters; busy=0, wr_valid=0, wr_addr=0, wr_data=0; MISO='z'.
REQ-020 rst mid-transaction SHALL abort without a write; the block SHALL then wait for a fresh CS high->low before entering CMD.

Configuration
REQ-021 With macro SPI_REG_AUTOINC_EN defined, address auto-increment per REQ-016 SHALL apply; undefined, the address SHALL stay fixed for the whole transaction (repeated access to one register).

Structure
REQ-022 A shared package SHALL hold the FSM state encoding (IDLE, CMD, DATA), the command bit positions (RW bit 7, address bits 3:0) and the address width constant.
REQ-023 A sub-module spi_edge_sync SHALL implement the synchronizer and rise/fall detection, instantiated once per SPI input.

Verification
REQ-024 Mode 0, write cmd 0x03, data 0xA5, 0x5A -> wr_valid twice: (3,0xA5), (4,0x5A); loc_rdata[3]=0xA5, loc_rdata[4]=0x5A.
REQ-025 Mode 3, read cmd 0x83 after REQ-024 -> MISO bytes 0xA5 then 0x5A; command byte MISO all 0.
REQ-026 Modes 1 and 2, write cmd 0x0F, data 0x11, 0x22 -> reg15=0x11, reg0=0x22 (wrap); without SPI_REG_AUTOINC_EN -> reg15=0x22.
REQ-027 CS rises after 5 bits of a data byte -> no wr_valid; busy falls after the sync delay; next transaction works normally.
REQ-028 rst asserted mid-read with CS low -> IDLE, MISO='z'; no transaction until CS toggles high then low.

Source files
------------

// File: rtl/spi_reg_slave_pkg.sv
// Shared types and constants for the SPI register slave: FSM encoding,
// command byte layout and the pending-write record.
package spi_reg_slave_pkg;

  localparam int ADDR_W       = 4;
  localparam int DATA_W       = 8;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 3;
  localparam int CMD_ADDR_LSB = 0;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_e;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wr_req_t;

  function automatic addr_t cmd_addr(input data_t cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI initiator-side signals plus mode pins; MISO is a separate tri-state port.
interface spi_reg_slave_if;
  logic SPI_SCLK;
  logic CS;
  logic MOSI;
  logic CPOL;
  logic CPHA;

  modport master (output SPI_SCLK, CS, MOSI, CPOL, CPHA);
  modport slave  (input  SPI_SCLK, CS, MOSI, CPOL, CPHA);
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI slave fronting a bank of 8-bit registers (modes 0-3).
// Define SPI_REG_AUTOINC_EN to step the address after every data byte.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int REG_COUNT   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_reg_slave_if.slave spi,
  output wire            MISO,
  output logic           busy,
  output logic           wr_valid,
  output addr_t          wr_addr,
  output data_t          wr_data,
  input  addr_t          loc_addr,
  output data_t          loc_rdata
);

`ifdef SPI_REG_AUTOINC_EN
  localparam addr_t ADDR_STEP = addr_t'(1);
`else
  localparam addr_t ADDR_STEP = '0;
`endif

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  // CS sync resets low so a CS held low through reset yields no fall edge:
  // a fresh high->low is needed before the next command.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk, .rst, .d(spi.SPI_SCLK), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk, .rst, .d(spi.CS), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk, .rst, .d(spi.MOSI), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_rise, mosi_rise, mosi_fall};

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  data_t      rx_q, rx_d;
  data_t      tx_q, tx_d;
  logic       skip_q, skip_d;
  logic       rd_q, rd_d;
  addr_t      addr_q, addr_d;
  wr_req_t    pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       wr_valid_q, wr_valid_d;
  addr_t      wr_addr_q, wr_addr_d;
  data_t      wr_data_q, wr_data_d;
  data_t      regs_q [REG_COUNT];
  data_t      regs_d [REG_COUNT];

  logic  lead, trail, sample, shift, load;
  data_t rx_next;

  always_comb begin
    lead    = spi.CPOL ? sclk_fall : sclk_rise;
    trail   = spi.CPOL ? sclk_rise : sclk_fall;
    sample  = spi.CPHA ? trail : lead;
    shift   = spi.CPHA ? lead  : trail;
    rx_next = {rx_q[DATA_W-2:0], mosi_s};
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    skip_d     = skip_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    pend_vld_d = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;
    load       = 1'b0;

    // Second stage of a write: commit and announce it.
    if (pend_vld_q) begin
      if (int'(pend_q.addr) < REG_COUNT) regs_d[pend_q.addr] = pend_q.data;
      wr_valid_d = 1'b1;
      wr_addr_d  = pend_q.addr;
      wr_data_d  = pend_q.data;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = '0;
          skip_d    = 1'b0;
          rd_d      = 1'b0;
        end
      end
      default: begin
        if (cs_s) begin
          // Deselect wins over any edge; a partial byte is simply dropped.
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_d      = '0;
          skip_d    = 1'b0;
        end else begin
          if (sample) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (sample && bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (state_q == CMD) begin
              state_d = DATA;
              rd_d    = rx_next[CMD_RW_BIT];
              addr_d  = cmd_addr(rx_next);
              load    = rx_next[CMD_RW_BIT];
            end else begin
              addr_d = addr_q + ADDR_STEP;
              if (rd_q) load = 1'b1;
              else begin
                pend_vld_d = 1'b1;
                pend_d     = '{addr: addr_q, data: rx_next};
              end
            end
          end
          // The first shift edge after a load belongs to the byte just
          // finished; consuming it keeps bit 7 on MISO for its sample edge.
          if (load) begin
            tx_d   = (int'(addr_d) < REG_COUNT) ? regs_q[addr_d] : '0;
            skip_d = 1'b1;
          end else if (shift && state_q == DATA && rd_q) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      skip_q     <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      skip_q     <= skip_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  logic miso_oe, miso_bit;
  assign miso_oe   = (state_q != IDLE);
  assign miso_bit  = (state_q == DATA) && rd_q && tx_q[DATA_W-1];
  assign MISO      = miso_oe ? miso_bit : 1'bz;

  assign busy      = (state_q != IDLE);
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign loc_rdata = (int'(loc_addr) < REG_COUNT) ? regs_q[loc_addr] : '0;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: write expectations are queued as bytes
// are driven and popped by a wr_valid monitor; read bytes via a MISO queue.
module tb_spi_reg_slave;

  localparam int HALF = 8;
  localparam int SYNC = 2;
`ifdef SPI_REG_AUTOINC_EN
  localparam logic [3:0] STEP = 4'd1;
`else
  localparam logic [3:0] STEP = 4'd0;
`endif

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  wire        miso;
  logic       busy, wr_valid;
  logic [3:0] wr_addr, loc_addr;
  logic [7:0] wr_data, loc_rdata;

  spi_reg_slave_if spi();

  spi_reg_slave #(.REG_COUNT(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi(spi), .MISO(miso), .busy(busy),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata));

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  wr_exp_t    exp_q[$];
  logic [7:0] exp_miso[$];
  logic [7:0] model [16];
  logic       prev_wv = 1'b0;

  always @(negedge clk) begin
    if (wr_valid) begin
      n_tests++;
      if (prev_wv) begin
        n_fail++;
        $display("FAIL wr_valid_width: wr_valid=1 on consecutive cycles, required a 1-cycle pulse");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got (%0d,0x%02h), required no write", wr_addr, wr_data);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          n_fail++;
          $display("FAIL wr_event: got (%0d,0x%02h), required (%0d,0x%02h)", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
    prev_wv = wr_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin(input logic cpol, input logic cpha);
    spi.CS = 1'b1; spi.CPOL = cpol; spi.CPHA = cpha; spi.SPI_SCLK = cpol; spi.MOSI = 1'b0;
    wait_clk(HALF);
    spi.CS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    spi.CS = 1'b1;
    wait_clk(SYNC + 6);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!spi.CPHA) begin
        spi.MOSI = tx[i];
        wait_clk(HALF);
        rx[i] = miso;
        spi.SPI_SCLK = ~spi.SPI_SCLK;
        wait_clk(HALF);
        spi.SPI_SCLK = ~spi.SPI_SCLK;
      end else begin
        spi.SPI_SCLK = ~spi.SPI_SCLK;
        spi.MOSI = tx[i];
        wait_clk(HALF);
        rx[i] = miso;
        spi.SPI_SCLK = ~spi.SPI_SCLK;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic do_write(input logic cpol, input logic cpha, input logic [3:0] a,
                          input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] rx;
    logic [3:0] wa;
    logic [7:0] dd [2];
    dd[0] = d0; dd[1] = d1;
    spi_begin(cpol, cpha);
    xfer({4'h0, a}, 8, rx);
    wa = a;
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back('{a: wa, d: dd[b]});
      model[wa] = dd[b];
      xfer(dd[b], 8, rx);
      n_tests++;
      if (rx !== 8'h00) begin
        n_fail++;
        $display("FAIL write_miso_zero: MISO byte 0x%02h during write data, required 0x00", rx);
      end
      wa = wa + STEP;
    end
    spi_end();
  endtask

  task automatic test_reset();
    spi.CS = 1'b1; spi.SPI_SCLK = 1'b0; spi.MOSI = 1'b0; spi.CPOL = 1'b0; spi.CPHA = 1'b0;
    loc_addr = '0;
    rst = 1'b1;
    for (int a = 0; a < 16; a++) model[a] = '0;
    wait_clk(5);
    n_tests++;
    if (busy !== 1'b0 || wr_valid !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b wr_valid=%b wr_addr=%0d wr_data=0x%02h, required all 0",
               busy, wr_valid, wr_addr, wr_data);
    end
    n_tests++;
    if (dut.miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_miso_z: MISO drive enable=%b, required 0 (high-Z)", dut.miso_oe);
    end
    rst = 1'b0;
    wait_clk(SYNC + 4);
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a); #1;
      n_tests++;
      if (loc_rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg: reg[%0d]=0x%02h, required 0x00", a, loc_rdata);
      end
    end
  endtask

  task automatic test_mode0_write();
    do_write(1'b0, 1'b0, 4'h3, 8'hA5, 8'h5A);
    wait_clk(4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mode0_write_count: %0d writes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    for (int a = 3; a < 5; a++) begin
      loc_addr = 4'(a); #1;
      n_tests++;
      if (loc_rdata !== model[a]) begin
        n_fail++;
        $display("FAIL mode0_reg: reg[%0d]=0x%02h, required 0x%02h", a, loc_rdata, model[a]);
      end
    end
  endtask

  task automatic test_mode3_read();
    logic [7:0] rx, e;
    logic [3:0] ra;
    spi_begin(1'b1, 1'b1);
    xfer(8'h83, 8, rx);
    n_tests++;
    if (rx !== 8'h00) begin
      n_fail++;
      $display("FAIL read_cmd_miso: MISO byte 0x%02h during command, required 0x00", rx);
    end
    ra = 4'h3;
    for (int b = 0; b < 2; b++) begin
      exp_miso.push_back(model[ra]);
      ra = ra + STEP;
    end
    for (int b = 0; b < 2; b++) begin
      xfer(8'h00, 8, rx);
      e = exp_miso.pop_front();
      n_tests++;
      if (rx !== e) begin
        n_fail++;
        $display("FAIL read_byte%0d: MISO byte 0x%02h, required 0x%02h", b, rx, e);
      end
    end
    spi_end();
  endtask

  task automatic test_wrap(input logic cpol, input logic cpha);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) model[a] = '0;
    do_write(cpol, cpha, 4'hF, 8'h11, 8'h22);
    wait_clk(4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_count mode%0d: %0d writes missing, required 0", {cpol, cpha}, exp_q.size());
      exp_q.delete();
    end
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a); #1;
      n_tests++;
      if (loc_rdata !== model[a]) begin
        n_fail++;
        $display("FAIL wrap_reg mode%0d: reg[%0d]=0x%02h, required 0x%02h", {cpol, cpha}, a, loc_rdata, model[a]);
      end
    end
  endtask

  task automatic test_partial();
    logic [7:0] rx;
    spi_begin(1'b0, 1'b0);
    xfer(8'h05, 8, rx);
    wait_clk(2);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_busy_hi: busy=%b mid-transaction, required 1", busy);
    end
    exp_q.push_back('{a: 4'h5, d: 8'h77});
    model[5] = 8'h77;
    xfer(8'h77, 8, rx);
    xfer(8'hC3, 5, rx);
    wait_clk(HALF);
    spi.CS = 1'b1;
    wait_clk(SYNC + 3);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_busy_lo: busy=%b after CS rise, required 0", busy);
    end
    wait_clk(20);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL partial_count: %0d writes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    do_write(1'b0, 1'b0, 4'h6, 8'h99, 8'h3C);
    wait_clk(4);
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a); #1;
      n_tests++;
      if (loc_rdata !== model[a]) begin
        n_fail++;
        $display("FAIL partial_reg: reg[%0d]=0x%02h, required 0x%02h", a, loc_rdata, model[a]);
      end
    end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] rx;
    spi_begin(1'b0, 1'b0);
    xfer(8'h86, 8, rx);
    xfer(8'h00, 3, rx);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) model[a] = '0;
    wait_clk(8);
    n_tests++;
    if (busy !== 1'b0 || dut.miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b miso_oe=%b, required 0/0", busy, dut.miso_oe);
    end
    // CS stays low: clocked bytes here must be ignored entirely.
    xfer(8'h01, 8, rx);
    xfer(8'hEE, 8, rx);
    wait_clk(8);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_rearm: busy=%b with CS never re-asserted, required 0", busy);
    end
    spi_end();
    do_write(1'b0, 1'b0, 4'h2, 8'h3C, 8'hC3);
    wait_clk(4);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_rearm_count: %0d writes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    for (int a = 0; a < 16; a++) begin
      loc_addr = 4'(a); #1;
      n_tests++;
      if (loc_rdata !== model[a]) begin
        n_fail++;
        $display("FAIL rst_rearm_reg: reg[%0d]=0x%02h, required 0x%02h", a, loc_rdata, model[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_mode3_read();
    test_wrap(1'b0, 1'b1);
    test_wrap(1'b1, 1'b0);
    test_partial();
    test_rst_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
